mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core.
- Replaces the separate instruction and data memory paths used by the single-cycle core.
- Accepts one request at a time, registers it, and drives it onto the shared port with a valid/ready handshake.
- Waits for the memory response and routes it back to the requester that owns the transaction.
- Only one transaction is outstanding at any time.

Parameters:
- XLEN, 32, address and data width.
- RR_EN, 1, 1 = round-robin on ties; 0 = fixed priority, LSU wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  XLEN  fetch address.
- ifu_rsp_valid  out  1  fetch data valid, 1-cycle pulse.
- ifu_rsp_data  out  XLEN  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_addr  in  XLEN  data address.
- lsu_req_wstrb  in  4  write byte strobe.
- lsu_req_wdata  in  XLEN  write data.
- lsu_rsp_valid  out  1  read data valid or write ack, 1-cycle pulse.
- lsu_rsp_data  out  XLEN  read data; 0 on write ack.
- mem_req_valid  out  1  shared port request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  XLEN  address.
- mem_req_wstrb  out  4  byte strobe; 0 for reads.
- mem_req_wdata  out  XLEN  write data.
- mem_rsp_valid  in  1  memory response valid.
- mem_rsp_data  in  XLEN  memory read data.

Behaviour:
- States: IDLE, REQ, RESP. Owner register: owner (0 = IFU, 1 = LSU). Round-robin history register: last_grant.
- Reset values:
  - state = IDLE, last_grant = LSU.
  - mem_req_valid = 0; ifu_/lsu_req_ready = 0; ifu_/lsu_rsp_valid = 0.
  - All latched request fields = 0; rsp_data = 0.
- Winner selection in IDLE:
  - Only one valid: that requester wins.
  - Both valid, RR_EN = 1: winner is the requester other than last_grant.
  - Both valid, RR_EN = 0: LSU wins.
- IDLE:
  - The winner's req_ready is asserted combinationally in the same cycle; the loser's ready stays 0.
  - On that clock edge: latch addr/wen/wstrb/wdata, set owner = winner, set last_grant = winner, go to REQ.
  - IFU requests latch wen = 0 and wstrb = 0.
  - No valid: stay in IDLE.
- REQ:
  - mem_req_valid = 1; mem_req_* driven from registers and stable until accepted.
  - mem_req_ready = 1: go to RESP.
  - Both req_ready outputs = 0.
- RESP:
  - mem_req_valid = 0.
  - On mem_rsp_valid: pulse the owner's rsp_valid for exactly 1 cycle and go to IDLE.
  - Response outputs are registered: rsp_valid is asserted in the cycle after mem_rsp_valid is sampled.
  - ifu_rsp_data / lsu_rsp_data carry mem_rsp_data for reads, 0 for an LSU write ack.
  - The non-owner's rsp_valid stays 0.
- Latency:
  - Request accepted in cycle T, mem_req_valid in T+1.
  - With mem_req_ready = 1 and mem_rsp_valid returned in the following cycle: response to requester at T+3.
  - Next acceptance possible at T+3: IDLE is re-entered together with the response pulse, which yields back-to-back throughput of 1 transaction per 3 cycles.
- mem_rsp_valid outside RESP is ignored. Memory must not respond before accepting the request.
- Requesters must hold req_valid and payload until req_ready; the arbiter samples the payload only in the accept cycle.
- Stalls: mem_req_ready low for N cycles holds REQ for N cycles with outputs unchanged. Unbounded stall in RESP is permitted; there is no timeout.
- Reset mid-operation (any state): next cycle state = IDLE, mem_req_valid = 0, no rsp_valid pulse, last_grant = LSU. Any in-flight response is discarded; the memory model is reset together with the arbiter.
- Starvation: with RR_EN = 1 and both requesters continuously valid, grants strictly alternate.

Test Plan:
- Single IFU fetch:
  - Stimulus: ifu_req_valid with addr 0x80000000; memory ready immediately, responds 1 cycle later with 0x00100093.
  - Required: ifu_req_ready pulses 1 cycle; ifu_rsp_valid pulses at T+3 with data 0x00100093; no lsu_rsp_valid.
- LSU write:
  - Stimulus: addr 0x80001000, wstrb 0x3, wdata 0xDEADBEEF.
  - Required: mem_req_wen = 1, wstrb = 0x3, wdata = 0xDEADBEEF; lsu_rsp_valid pulse with data 0.
- Tie, RR_EN = 1, both requesters held valid for 4 transactions:
  - Required: grant order IFU, LSU, IFU, LSU; each response is routed only to its owner.
- Tie, RR_EN = 0:
  - Required: LSU granted first; IFU waits with ifu_req_ready = 0 until the LSU response.
- Backpressure:
  - Stimulus: mem_req_ready held low 5 cycles, then high.
  - Required: mem_req_valid high 6 cycles; addr/wdata stable throughout; exactly one transaction issued.
- Reset in RESP:
  - Stimulus: rst asserted 1 cycle, then a late mem_rsp_valid.
  - Required: state = IDLE, no rsp_valid pulse to either requester; the next IFU/LSU tie grants IFU.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and shared memory port signals of the arbiter
interface mem_arbiter_if #(parameter int XLEN = 32);
   logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [XLEN-1:0] ifu_req_addr, ifu_rsp_data;
   logic            lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
   logic [XLEN-1:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
   logic [3:0]      lsu_req_wstrb;
   logic            mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
   logic [XLEN-1:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
   logic [3:0]      mem_req_wstrb;
   modport master (
      input  ifu_req_valid, ifu_req_addr,
      input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wstrb, lsu_req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata
   );
   modport slave (
      output ifu_req_valid, ifu_req_addr,
      output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wstrb, lsu_req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight
module mem_arbiter #(
   parameter int XLEN  = 32,
   parameter bit RR_EN = 1'b1
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t          state;
   logic            owner, last_grant, win_lsu, accept, wen;
   logic [XLEN-1:0] addr, wdata;
   logic [3:0]      wstrb;
   // winner selection and same-cycle ready; latched request drives the memory port
   always_comb begin
      win_lsu           = bus.lsu_req_valid && (!bus.ifu_req_valid || !RR_EN || !last_grant);
      accept            = !rst && state == IDLE && (bus.ifu_req_valid || bus.lsu_req_valid);
      bus.lsu_req_ready = accept && win_lsu;
      bus.ifu_req_ready = accept && !win_lsu;
      bus.mem_req_wen   = wen;
      bus.mem_req_addr  = addr;
      bus.mem_req_wstrb = wstrb;
      bus.mem_req_wdata = wdata;
   end
   // transaction FSM with registered port and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         owner             <= 1'b0;
         last_grant        <= 1'b1;
         wen               <= 1'b0;
         addr              <= '0;
         wstrb             <= '0;
         wdata             <= '0;
         bus.mem_req_valid <= 1'b0;
         bus.ifu_rsp_valid <= 1'b0;
         bus.lsu_rsp_valid <= 1'b0;
         bus.ifu_rsp_data  <= '0;
         bus.lsu_rsp_data  <= '0;
      end else begin
         bus.ifu_rsp_valid <= 1'b0;
         bus.lsu_rsp_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               state             <= REQ;
               owner             <= win_lsu;
               last_grant        <= win_lsu;
               wen               <= win_lsu && bus.lsu_req_wen;
               addr              <= win_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
               wstrb             <= (win_lsu && bus.lsu_req_wen) ? bus.lsu_req_wstrb : 4'h0;
               wdata             <= win_lsu ? bus.lsu_req_wdata : '0;
               bus.mem_req_valid <= 1'b1;
            end
            REQ: if (bus.mem_req_ready) begin
               state             <= RESP;
               bus.mem_req_valid <= 1'b0;
            end
            RESP: if (bus.mem_rsp_valid) begin
               state <= IDLE;
               if (owner) begin
                  bus.lsu_rsp_valid <= 1'b1;
                  bus.lsu_rsp_data  <= wen ? '0 : bus.mem_rsp_data;
               end else begin
                  bus.ifu_rsp_valid <= 1'b1;
                  bus.ifu_rsp_data  <= bus.mem_rsp_data;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a round-robin and a fixed-priority arbiter driven in lockstep
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        ifu_v = 1'b0, lsu_v = 1'b0, lsu_wen = 1'b0, mrdy = 1'b0, mrv = 1'b0;
   logic [31:0] ifu_a = '0, lsu_a = '0, lsu_d = '0, mrd = '0;
   logic [3:0]  lsu_s = '0;
   int          n = 0, errs = 0;
   int          cnt [2];
   logic [31:0] adr0 [2];
   logic [31:0] dat0 [2];
   logic        mv [2], ir [2], lr [2], iv [2], lv [2], mw [2];
   logic [31:0] ma [2], md [2], id [2], ld [2];
   logic [3:0]  ms [2];

   always #5 clk = ~clk;

   mem_arbiter_if #(.XLEN(32)) ba ();
   mem_arbiter_if #(.XLEN(32)) bb ();
   mem_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ba.master));
   mem_arbiter #(.XLEN(32), .RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bb.master));

   assign ba.ifu_req_valid = ifu_v;   assign bb.ifu_req_valid = ifu_v;
   assign ba.ifu_req_addr  = ifu_a;   assign bb.ifu_req_addr  = ifu_a;
   assign ba.lsu_req_valid = lsu_v;   assign bb.lsu_req_valid = lsu_v;
   assign ba.lsu_req_wen   = lsu_wen; assign bb.lsu_req_wen   = lsu_wen;
   assign ba.lsu_req_addr  = lsu_a;   assign bb.lsu_req_addr  = lsu_a;
   assign ba.lsu_req_wstrb = lsu_s;   assign bb.lsu_req_wstrb = lsu_s;
   assign ba.lsu_req_wdata = lsu_d;   assign bb.lsu_req_wdata = lsu_d;
   assign ba.mem_req_ready = mrdy;    assign bb.mem_req_ready = mrdy;
   assign ba.mem_rsp_valid = mrv;     assign bb.mem_rsp_valid = mrv;
   assign ba.mem_rsp_data  = mrd;     assign bb.mem_rsp_data  = mrd;

   assign mv[0] = ba.mem_req_valid; assign mv[1] = bb.mem_req_valid;
   assign ir[0] = ba.ifu_req_ready; assign ir[1] = bb.ifu_req_ready;
   assign lr[0] = ba.lsu_req_ready; assign lr[1] = bb.lsu_req_ready;
   assign iv[0] = ba.ifu_rsp_valid; assign iv[1] = bb.ifu_rsp_valid;
   assign lv[0] = ba.lsu_rsp_valid; assign lv[1] = bb.lsu_rsp_valid;
   assign id[0] = ba.ifu_rsp_data;  assign id[1] = bb.ifu_rsp_data;
   assign ld[0] = ba.lsu_rsp_data;  assign ld[1] = bb.lsu_rsp_data;
   assign mw[0] = ba.mem_req_wen;   assign mw[1] = bb.mem_req_wen;
   assign ma[0] = ba.mem_req_addr;  assign ma[1] = bb.mem_req_addr;
   assign md[0] = ba.mem_req_wdata; assign md[1] = bb.mem_req_wdata;
   assign ms[0] = ba.mem_req_wstrb; assign ms[1] = bb.mem_req_wstrb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // one full transaction with requests already presented; ea/eb = LSU expected to win on each DUT
   task automatic txn(input string tag, input logic ea, input logic eb, input logic [31:0] rd, input bit drop);
      logic e;
      #1;
      for (int d = 0; d < 2; d++) begin
         e = d ? eb : ea;
         chk($sformatf("%s.ifu_rdy%0d", tag, d), ir[d], !e);
         chk($sformatf("%s.lsu_rdy%0d", tag, d), lr[d], e);
      end
      step;
      if (drop) begin ifu_v = 1'b0; lsu_v = 1'b0; end
      mrdy = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         e = d ? eb : ea;
         chk($sformatf("%s.mvalid%0d", tag, d), mv[d], 1'b1);
         chk($sformatf("%s.maddr%0d", tag, d), ma[d], e ? lsu_a : ifu_a);
         chk($sformatf("%s.mwen%0d", tag, d), mw[d], e && lsu_wen);
         chk($sformatf("%s.mstrb%0d", tag, d), ms[d], (e && lsu_wen) ? lsu_s : 4'h0);
         if (e && lsu_wen) chk($sformatf("%s.mwdata%0d", tag, d), md[d], lsu_d);
         chk($sformatf("%s.rdy_req%0d", tag, d), ir[d] | lr[d], 1'b0);
      end
      step;
      mrdy = 1'b0; mrv = 1'b1; mrd = rd;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.mvalid_resp%0d", tag, d), mv[d], 1'b0);
         chk($sformatf("%s.rdy_resp%0d", tag, d), ir[d] | lr[d], 1'b0);
         chk($sformatf("%s.no_early_rsp%0d", tag, d), iv[d] | lv[d], 1'b0);
      end
      step;
      mrv = 1'b0;
      for (int d = 0; d < 2; d++) begin
         e = d ? eb : ea;
         chk($sformatf("%s.ifu_rsp%0d", tag, d), iv[d], !e);
         chk($sformatf("%s.lsu_rsp%0d", tag, d), lv[d], e);
         if (e) chk($sformatf("%s.lsu_data%0d", tag, d), ld[d], lsu_wen ? 32'h0 : rd);
         else   chk($sformatf("%s.ifu_data%0d", tag, d), id[d], rd);
      end
   endtask

   initial begin
      step; step;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst.mvalid%0d", d), mv[d], 1'b0);
         chk($sformatf("rst.rdy%0d", d), ir[d] | lr[d], 1'b0);
         chk($sformatf("rst.rsp%0d", d), iv[d] | lv[d], 1'b0);
         chk($sformatf("rst.rdata%0d", d), id[d] | ld[d], 32'h0);
         chk($sformatf("rst.maddr%0d", d), ma[d], 32'h0);
         chk($sformatf("rst.mstrb%0d", d), ms[d], 4'h0);
      end
      rst = 1'b0;
      step;
      for (int d = 0; d < 2; d++) chk($sformatf("idle.rdy%0d", d), ir[d] | lr[d], 1'b0);
      // single IFU fetch
      ifu_v = 1'b1; ifu_a = 32'h8000_0000;
      txn("fetch", 1'b0, 1'b0, 32'h0010_0093, 1'b1);
      step;
      for (int d = 0; d < 2; d++) chk($sformatf("fetch.pulse_end%0d", d), iv[d] | lv[d], 1'b0);
      // LSU write
      lsu_v = 1'b1; lsu_wen = 1'b1; lsu_a = 32'h8000_1000; lsu_s = 4'h3; lsu_d = 32'hDEAD_BEEF;
      txn("wr", 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
      // LSU read: strobe must not reach the port
      lsu_v = 1'b1; lsu_wen = 1'b0; lsu_a = 32'h8000_2000; lsu_s = 4'hF;
      txn("rd", 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
      // ties, back to back: alternating on round-robin, LSU always on fixed priority
      ifu_v = 1'b1; ifu_a = 32'h8000_0004; lsu_v = 1'b1; lsu_a = 32'h8000_2004;
      txn("tie0", 1'b0, 1'b1, 32'h1111_0000, 1'b0);
      txn("tie1", 1'b1, 1'b1, 32'h2222_0000, 1'b0);
      txn("tie2", 1'b0, 1'b1, 32'h3333_0000, 1'b0);
      txn("tie3", 1'b1, 1'b1, 32'h4444_0000, 1'b1);
      // backpressure: five stalled cycles then acceptance
      lsu_v = 1'b1; lsu_wen = 1'b1; lsu_a = 32'h8000_3000; lsu_s = 4'hF; lsu_d = 32'h1234_5678;
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("bp.lsu_rdy%0d", d), lr[d], 1'b1);
      step;
      lsu_v = 1'b0;
      lsu_a = 32'h0; lsu_d = 32'h0;
      for (int d = 0; d < 2; d++) begin cnt[d] = 0; adr0[d] = ma[d]; dat0[d] = md[d]; end
      for (int i = 0; i < 6; i++) begin
         mrdy = (i == 5);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (mv[d]) cnt[d]++;
            chk($sformatf("bp.addr%0d_%0d", d, i), ma[d], 32'h8000_3000);
            chk($sformatf("bp.wdata%0d_%0d", d, i), md[d], 32'h1234_5678);
         end
         step;
      end
      mrdy = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("bp.valid_cycles%0d", d), cnt[d], 6);
         chk($sformatf("bp.mvalid_done%0d", d), mv[d], 1'b0);
         chk($sformatf("bp.addr_latched%0d", d), adr0[d], 32'h8000_3000);
         chk($sformatf("bp.wdata_latched%0d", d), dat0[d], 32'h1234_5678);
      end
      mrv = 1'b1; mrd = 32'h9999_9999;
      step;
      mrv = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("bp.lsu_rsp%0d", d), lv[d], 1'b1);
         chk($sformatf("bp.lsu_data%0d", d), ld[d], 32'h0);
      end
      step; step;
      for (int d = 0; d < 2; d++) chk($sformatf("bp.single_txn%0d", d), mv[d] | iv[d] | lv[d], 1'b0);
      // reset while waiting in RESP, then a late memory response
      ifu_v = 1'b1; ifu_a = 32'h8000_0100;
      step;
      ifu_v = 1'b0; mrdy = 1'b1;
      step;
      mrdy = 1'b0; rst = 1'b1;
      step;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("mrst.mvalid%0d", d), mv[d], 1'b0);
         chk($sformatf("mrst.rsp%0d", d), iv[d] | lv[d], 1'b0);
      end
      mrv = 1'b1; mrd = 32'h7777_7777;
      step;
      mrv = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("mrst.late_mvalid%0d", d), mv[d], 1'b0);
         chk($sformatf("mrst.late_rsp%0d", d), iv[d] | lv[d], 1'b0);
      end
      step;
      for (int d = 0; d < 2; d++) chk($sformatf("mrst.late_rsp2_%0d", d), iv[d] | lv[d], 1'b0);
      ifu_v = 1'b1; ifu_a = 32'h8000_0200; lsu_v = 1'b1; lsu_wen = 1'b0; lsu_a = 32'h8000_4000;
      txn("mrst.tie", 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b1);
      step;
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
